decode_hazard_unit: RTL and testbench

Consumes the per-instruction fields captured by the decode pipeline registers and decides each cycle whether the decoded instruction may advance into execute. It tracks in-flight destination registers in a small shift scoreboard and generates `stall_out` (hold fetch and decode registers) and `flush_out` (squash fetch and decode after a taken branch). It sits between the decode register bank and execute, and drives the stall and flush controls back to the fetch and decode registers.

---
 rtl/decode_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_decode_hazard_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit: decides each cycle whether the decoded instruction may
// issue into execute, using a shift scoreboard of in-flight destinations.
// Drives stall (hold fetch/decode) and flush (squash after a taken branch).
//
// Build option: DECODE_HAZARD_FORWARDING_EN
//   defined   -> execute forwards results, so only a load in entry 0 causes
//                a hazard (single load-use bubble).
//   undefined -> any valid in-flight writer causes a hazard until it retires.
//
// Flush counter
//   value | meaning
//   0     | not flushing, normal issue/stall decisions
//   1..N  | flushing; fetch/decode squashed, nothing issues
module decode_hazard_unit #(
   parameter int REGISTER_INDEX = 5,
   parameter int PIPE_DEPTH     = 3,
   parameter int FLUSH_CYCLES   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      decode_valid_in,
   input  logic [REGISTER_INDEX-1:0] first_register_in,
   input  logic [REGISTER_INDEX-1:0] second_register_in,
   input  logic [REGISTER_INDEX-1:0] destination_register_in,
   input  logic                      cu_reg_write_in,
   input  logic                      cu_mem_read_in,
   input  logic                      cu_mem_write_in,
   input  logic                      cu_alu_src_in,
   input  logic                      branch_taken_in,
   output logic                      issue_out,
   output logic                      stall_out,
   output logic                      flush_out,
   output logic [31:0]               stall_count_out
);

   localparam int FLUSH_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES);

   // Scoreboard: entry 0 is the instruction in execute, higher indices are older.
   logic [PIPE_DEPTH-1:0]     sb_valid_q, sb_valid_d;
   logic [PIPE_DEPTH-1:0]     sb_load_q, sb_load_d;
   logic [REGISTER_INDEX-1:0] sb_rd_q [PIPE_DEPTH];
   logic [REGISTER_INDEX-1:0] sb_rd_d [PIPE_DEPTH];

   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [31:0]        stall_count_q, stall_count_d;

   logic                  flushing;
   logic                  src2_used;
   logic                  hazard;
   logic [PIPE_DEPTH-1:0] entry_hit;
   logic                  lint_unused_bits;

   assign flushing = (flush_cnt_q != '0);

   // Per-entry source match; x0 is hardwired so it never creates a dependence.
   always_comb begin
      src2_used = !cu_alu_src_in || cu_mem_write_in;
      entry_hit = '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         entry_hit[i] = sb_valid_q[i] &&
                        (((first_register_in != '0) && (first_register_in == sb_rd_q[i])) ||
                         (src2_used && (second_register_in != '0) &&
                          (second_register_in == sb_rd_q[i])));
      end
   end

   // Select which scoreboard entries can block issue.
   always_comb begin
      hazard = 1'b0;
`ifdef DECODE_HAZARD_FORWARDING_EN
      hazard = entry_hit[0] && sb_load_q[0];
`else
      hazard = |entry_hit;
`endif
   end

   // Only part of the load flags / hit vector matter in each build.
   assign lint_unused_bits = ^{sb_load_q, entry_hit};

   // Issue/stall decision; a taken branch and an active flush both override stall.
   always_comb begin
      stall_out = decode_valid_in && hazard && !flushing && !branch_taken_in;
      issue_out = decode_valid_in && !stall_out && !flushing && !branch_taken_in;
      flush_out = flushing;
      stall_count_out = stall_count_q;
   end

   // Next state: scoreboard shift, flush countdown, saturating stall counter.
   always_comb begin
      sb_valid_d = '0;
      sb_load_d  = '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         sb_rd_d[i] = '0;
      end

      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
         sb_valid_d[i] = sb_valid_q[i-1];
         sb_load_d[i]  = sb_load_q[i-1];
         sb_rd_d[i]    = sb_rd_q[i-1];
      end

      if (issue_out) begin
         sb_valid_d[0] = cu_reg_write_in && (destination_register_in != '0);
         sb_load_d[0]  = cu_mem_read_in;
         sb_rd_d[0]    = destination_register_in;
      end

      if (branch_taken_in) begin
         flush_cnt_d = FLUSH_LOAD;
      end else if (flushing) begin
         flush_cnt_d = flush_cnt_q - 1'b1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end

      if (stall_out && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end else begin
         stall_count_d = stall_count_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_valid_q    <= '0;
         sb_load_q     <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            sb_rd_q[i] <= '0;
         end
         flush_cnt_q   <= '0;
         stall_count_q <= '0;
      end else begin
         sb_valid_q    <= sb_valid_d;
         sb_load_q     <= sb_load_d;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            sb_rd_q[i] <= sb_rd_d[i];
         end
         flush_cnt_q   <= flush_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Bench for decode_hazard_unit (default parameters). Expectations adapt to
// DECODE_HAZARD_FORWARDING_EN so the same bench covers both builds.
module tb_decode_hazard_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        decode_valid_in = 1'b1;
   logic [4:0]  first_register_in = '0;
   logic [4:0]  second_register_in = '0;
   logic [4:0]  destination_register_in = '0;
   logic        cu_reg_write_in = 1'b0;
   logic        cu_mem_read_in = 1'b0;
   logic        cu_mem_write_in = 1'b0;
   logic        cu_alu_src_in = 1'b0;
   logic        branch_taken_in = 1'b0;
   logic        issue_out;
   logic        stall_out;
   logic        flush_out;
   logic [31:0] stall_count_out;

   int n_cmp = 0;
   int n_err = 0;

`ifdef DECODE_HAZARD_FORWARDING_EN
   localparam int N_LOAD_USE = 1;
   localparam int N_RAW      = 0;
`else
   localparam int N_LOAD_USE = 3;
   localparam int N_RAW      = 3;
`endif

   typedef struct packed {
      logic issue;
      logic stall;
      logic flush;
   } exp_t;

   typedef struct {
      logic       rst;
      logic       v;
      logic [4:0] rs1, rs2, rd;
      logic       regw, memr, memw, alusrc, br;
      exp_t       e;
   } step_t;

   exp_t exp_q[$];

   decode_hazard_unit dut (
      .clk                     (clk),
      .reset                   (reset),
      .decode_valid_in         (decode_valid_in),
      .first_register_in       (first_register_in),
      .second_register_in      (second_register_in),
      .destination_register_in (destination_register_in),
      .cu_reg_write_in         (cu_reg_write_in),
      .cu_mem_read_in          (cu_mem_read_in),
      .cu_mem_write_in         (cu_mem_write_in),
      .cu_alu_src_in           (cu_alu_src_in),
      .branch_taken_in         (branch_taken_in),
      .issue_out               (issue_out),
      .stall_out               (stall_out),
      .flush_out               (flush_out),
      .stall_count_out         (stall_count_out)
   );

   always #5 clk = ~clk;

   function automatic step_t st(input logic rst, input logic v,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic regw,
                                input logic memr, input logic memw,
                                input logic alusrc, input logic br,
                                input logic ei, input logic es, input logic ef);
      step_t s;
      s.rst = rst; s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
      s.regw = regw; s.memr = memr; s.memw = memw; s.alusrc = alusrc; s.br = br;
      s.e.issue = ei; s.e.stall = es; s.e.flush = ef;
      return s;
   endfunction

   // Drive one cycle of stimulus just after the edge and queue its expectation.
   task automatic apply(input step_t s);
      @(posedge clk); #1;
      reset                   = s.rst;
      decode_valid_in         = s.v;
      first_register_in       = s.rs1;
      second_register_in      = s.rs2;
      destination_register_in = s.rd;
      cu_reg_write_in         = s.regw;
      cu_mem_read_in          = s.memr;
      cu_mem_write_in         = s.memw;
      cu_alu_src_in           = s.alusrc;
      branch_taken_in         = s.br;
      exp_q.push_back(s.e);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; decode_valid_in = 1'b0; branch_taken_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      repeat (2) @(posedge clk);
      @(negedge clk);
      e = '{issue: 1'b1, stall: 1'b0, flush: 1'b0};
      n_cmp++;
      if (stall_out !== e.stall) begin
         n_err++; $display("FAIL reset_stall got %b want %b", stall_out, e.stall);
      end
      n_cmp++;
      if (flush_out !== e.flush) begin
         n_err++; $display("FAIL reset_flush got %b want %b", flush_out, e.flush);
      end
      n_cmp++;
      if (issue_out !== e.issue) begin
         n_err++; $display("FAIL reset_issue got %b want %b", issue_out, e.issue);
      end
      n_cmp++;
      if (stall_count_out !== 32'd0) begin
         n_err++; $display("FAIL reset_count got %0d want 0", stall_count_out);
      end
      @(posedge clk); #1;
      reset = 1'b0; decode_valid_in = 1'b0;
   endtask

   task automatic test_load_use();
      step_t steps[$];
      exp_t  e;
      do_reset();
      // lw x5, 0(x1)
      steps.push_back(st(0,1, 5'd1,5'd0,5'd5, 1,1,0,1,0, 1,0,0));
      // add x6, x5, x1 : stalls then issues
      for (int k = 0; k < N_LOAD_USE; k++)
         steps.push_back(st(0,1, 5'd5,5'd1,5'd6, 1,0,0,0,0, 0,1,0));
      steps.push_back(st(0,1, 5'd5,5'd1,5'd6, 1,0,0,0,0, 1,0,0));
      steps.push_back(st(0,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, 0,0,0));
      for (int i = 0; i < steps.size(); i++) begin
         apply(steps[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({issue_out, stall_out, flush_out} !== {e.issue, e.stall, e.flush}) begin
            n_err++;
            $display("FAIL load_use step %0d issue/stall/flush got %b%b%b want %b%b%b",
                     i, issue_out, stall_out, flush_out, e.issue, e.stall, e.flush);
         end
      end
      n_cmp++;
      if (stall_count_out !== 32'(N_LOAD_USE)) begin
         n_err++; $display("FAIL load_use_count got %0d want %0d", stall_count_out, N_LOAD_USE);
      end
   endtask

   task automatic test_raw();
      step_t steps[$];
      exp_t  e;
      do_reset();
      // add x5, x3, x4
      steps.push_back(st(0,1, 5'd3,5'd4,5'd5, 1,0,0,0,0, 1,0,0));
      // sub x7, x5, x2
      for (int k = 0; k < N_RAW; k++)
         steps.push_back(st(0,1, 5'd5,5'd2,5'd7, 1,0,0,0,0, 0,1,0));
      steps.push_back(st(0,1, 5'd5,5'd2,5'd7, 1,0,0,0,0, 1,0,0));
      // add x8 then sw x8 via rs2 (store makes rs2 a source)
      steps.push_back(st(0,1, 5'd1,5'd2,5'd8, 1,0,0,0,0, 1,0,0));
      for (int k = 0; k < N_RAW; k++)
         steps.push_back(st(0,1, 5'd3,5'd8,5'd0, 0,0,1,1,0, 0,1,0));
      steps.push_back(st(0,1, 5'd3,5'd8,5'd0, 0,0,1,1,0, 1,0,0));
      for (int i = 0; i < steps.size(); i++) begin
         apply(steps[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({issue_out, stall_out, flush_out} !== {e.issue, e.stall, e.flush}) begin
            n_err++;
            $display("FAIL raw step %0d issue/stall/flush got %b%b%b want %b%b%b",
                     i, issue_out, stall_out, flush_out, e.issue, e.stall, e.flush);
         end
      end
      n_cmp++;
      if (stall_count_out !== 32'(2 * N_RAW)) begin
         n_err++; $display("FAIL raw_count got %0d want %0d", stall_count_out, 2 * N_RAW);
      end
   endtask

   task automatic test_imm_x0();
      step_t steps[$];
      exp_t  e;
      do_reset();
      // addi x5, x1, imm
      steps.push_back(st(0,1, 5'd1,5'd0,5'd5, 1,0,0,1,0, 1,0,0));
      // addi x6, x0, imm with rs2 field = 5 -> rs2 not a source
      steps.push_back(st(0,1, 5'd0,5'd5,5'd6, 1,0,0,1,0, 1,0,0));
      // writer to x0
      steps.push_back(st(0,1, 5'd1,5'd2,5'd0, 1,1,0,0,0, 1,0,0));
      // reader of x0 on both operands
      steps.push_back(st(0,1, 5'd0,5'd0,5'd9, 1,0,0,0,0, 1,0,0));
      for (int i = 0; i < steps.size(); i++) begin
         apply(steps[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({issue_out, stall_out, flush_out} !== {e.issue, e.stall, e.flush}) begin
            n_err++;
            $display("FAIL imm_x0 step %0d issue/stall/flush got %b%b%b want %b%b%b",
                     i, issue_out, stall_out, flush_out, e.issue, e.stall, e.flush);
         end
      end
      n_cmp++;
      if (stall_count_out !== 32'd0) begin
         n_err++; $display("FAIL imm_x0_count got %0d want 0", stall_count_out);
      end
   endtask

   task automatic test_branch();
      step_t steps[$];
      exp_t  e;
      do_reset();
      // lw x5 issues, then add x6,x5,x1 meets a taken branch at T
      steps.push_back(st(0,1, 5'd1,5'd0,5'd5, 1,1,0,1,0, 1,0,0));
      steps.push_back(st(0,1, 5'd5,5'd1,5'd6, 1,0,0,0,1, 0,0,0));
      steps.push_back(st(0,1, 5'd5,5'd1,5'd6, 1,0,0,0,0, 0,0,1));
      steps.push_back(st(0,1, 5'd5,5'd1,5'd6, 1,0,0,0,0, 0,0,1));
      // lw has retired and the branch slot was a bubble: no hazard left
      steps.push_back(st(0,1, 5'd5,5'd1,5'd6, 1,0,0,0,0, 1,0,0));
      // second branch while flushing reloads the counter
      steps.push_back(st(0,0, 5'd0,5'd0,5'd0, 0,0,0,0,1, 0,0,0));
      steps.push_back(st(0,1, 5'd1,5'd2,5'd3, 1,0,0,0,1, 0,0,1));
      steps.push_back(st(0,1, 5'd1,5'd2,5'd3, 1,0,0,0,0, 0,0,1));
      steps.push_back(st(0,1, 5'd1,5'd2,5'd3, 1,0,0,0,0, 0,0,1));
      steps.push_back(st(0,1, 5'd1,5'd2,5'd3, 1,0,0,0,0, 1,0,0));
      for (int i = 0; i < steps.size(); i++) begin
         apply(steps[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({issue_out, stall_out, flush_out} !== {e.issue, e.stall, e.flush}) begin
            n_err++;
            $display("FAIL branch step %0d issue/stall/flush got %b%b%b want %b%b%b",
                     i, issue_out, stall_out, flush_out, e.issue, e.stall, e.flush);
         end
      end
      n_cmp++;
      if (stall_count_out !== 32'd0) begin
         n_err++; $display("FAIL branch_count got %0d want 0", stall_count_out);
      end
   endtask

   task automatic test_reset_mid_flush();
      step_t steps[$];
      exp_t  e;
      do_reset();
      // add x9 issues, branch at T, reset at T+1, reader of x9 at T+2
      steps.push_back(st(0,1, 5'd1,5'd2,5'd9, 1,0,0,0,0, 1,0,0));
      steps.push_back(st(0,0, 5'd0,5'd0,5'd0, 0,0,0,0,1, 0,0,0));
      steps.push_back(st(1,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, 0,0,1));
      steps.push_back(st(0,1, 5'd9,5'd9,5'd4, 1,0,0,0,0, 1,0,0));
      steps.push_back(st(0,0, 5'd0,5'd0,5'd0, 0,0,0,0,0, 0,0,0));
      for (int i = 0; i < steps.size(); i++) begin
         apply(steps[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({issue_out, stall_out, flush_out} !== {e.issue, e.stall, e.flush}) begin
            n_err++;
            $display("FAIL reset_mid_flush step %0d issue/stall/flush got %b%b%b want %b%b%b",
                     i, issue_out, stall_out, flush_out, e.issue, e.stall, e.flush);
         end
      end
      n_cmp++;
      if (stall_count_out !== 32'd0) begin
         n_err++; $display("FAIL reset_mid_flush_count got %0d want 0", stall_count_out);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_raw();
      test_imm_x0();
      test_branch();
      test_reset_mid_flush();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
